// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) in WIDTH iteration
//   cycles plus one sign-fixup cycle. MTHI/MTLO write HI/LO in a single cycle.
//
// Ports
//   clk     in   1      rising-edge clock
//   resetN  in   1      asynchronous active-low reset
//   start   in   1      request, accepted only while busy=0
//   op      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                       100 MTHI, 101 MTLO, others NOP
//   opA     in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//   opB     in   WIDTH  multiplier / divisor
//   flush   in   1      abort the in-flight op; HI/LO keep prior values
//   busy    out  1      op in flight; new starts ignored
//   done    out  1      one-cycle pulse after HI/LO were written by MULT*/DIV*
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Magnitude of a value; only negated when the op is signed and v is negative.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    mag = (sgn && v[WIDTH-1]) ? (-v) : v;
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient bits}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     m_q, m_d;          // multiplicand or divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d; // negate product / quotient in FIX
  logic                 neg_hi_q, neg_hi_d; // negate remainder in FIX
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 op_signed_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_trial_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     quo_s;

  assign op_signed_s = (op == OP_MULT) || (op == OP_DIV);
  assign rem_s       = acc_q[2*WIDTH-1:WIDTH];
  assign quo_s       = acc_q[WIDTH-1:0];

  // One shift-add step and one restoring-divide step from the current accumulator.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
    // Shifted remainder fits in WIDTH+1 bits; bit WIDTH of the difference is the
    // borrow whenever the divisor is non-zero.
    div_trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
    if (div_trial_s[WIDTH]) begin
      div_next_s = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          // A flush while idle swallows any simultaneous request.
          state_d = S_IDLE;
        end else if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d  = S_RUN;
              cnt_d    = CNT_LOAD;
              m_d      = mag(opA, op_signed_s);
              acc_d    = {{WIDTH{1'b0}}, mag(opB, op_signed_s)};
              is_div_d = 1'b0;
              neg_lo_d = op_signed_s && (opA[WIDTH-1] ^ opB[WIDTH-1]);
              neg_hi_d = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state_d  = S_RUN;
              cnt_d    = CNT_LOAD;
              m_d      = mag(opB, op_signed_s);
              acc_d    = {{WIDTH{1'b0}}, mag(opA, op_signed_s)};
              is_div_d = 1'b1;
              neg_lo_d = op_signed_s && (opA[WIDTH-1] ^ opB[WIDTH-1]);
              neg_hi_d = op_signed_s && opA[WIDTH-1];
            end
            OP_MTHI: begin
              hi_d = opA;
            end
            OP_MTLO: begin
              lo_d = opA;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          acc_d = is_div_q ? div_next_s : mul_next_s;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_FIX;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = neg_lo_q ? (-acc_q) : acc_q;
          end else if (m_q == {WIDTH{1'b0}}) begin
            // Divide by zero: the remainder field has shifted the dividend
            // magnitude back in unchanged, so re-applying the dividend sign
            // reproduces opA exactly.
            lo_d = {WIDTH{1'b1}};
            hi_d = neg_hi_q ? (-rem_s) : rem_s;
          end else begin
            lo_d = neg_lo_q ? (-quo_s) : quo_s;
            hi_d = neg_hi_q ? (-rem_s) : rem_s;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      acc_q    <= {(2*WIDTH){1'b0}};
      m_q      <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
